// File: rtl/top.sv
// Single-block SHA-256 engine: pads a fixed-length message into one 512-bit block
// and runs 64 rounds, one per clock, with a 16-word sliding message schedule.
module top #(
  parameter int MSG_SIZE    = 120,
  parameter int PADDED_SIZE = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MSG_SIZE-1:0] message,
  output logic [255:0]        hashed
);

  typedef enum logic [1:0] {IDLE, COMPUTE, FINAL, DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  state_t state, state_next;

  logic [5:0]             round;
  logic [31:0]            w [16];
  logic [31:0]            a, b, c, d, e, f, g, h;
  logic [PADDED_SIZE-1:0] padded;
  logic [31:0]            t1, t2, w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message, a single 1 bit just below it, and the bit length in the low 64 bits
  assign padded = {message, {(PADDED_SIZE-MSG_SIZE){1'b0}}}
                | ({{(PADDED_SIZE-1){1'b0}}, 1'b1} << (PADDED_SIZE - 1 - MSG_SIZE))
                | {{(PADDED_SIZE-64){1'b0}}, 64'(MSG_SIZE)};

  // w[0] is always W[t]; w_new is W[t+16] built from the rest of the window
  always_comb begin
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[round] + w[0];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COMPUTE;
      COMPUTE: if (round == 6'd63) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hashed <= '0;
      round  <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) w[i] <= padded[PADDED_SIZE-1-32*i -: 32];
            {a, b, c, d, e, f, g, h} <= H_INIT;
            round <= '0;
          end
        end
        COMPUTE: begin
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          round <= round + 6'd1;
        end
        FINAL: begin
          hashed <= {H_INIT[255:224] + a, H_INIT[223:192] + b,
                     H_INIT[191:160] + c, H_INIT[159:128] + d,
                     H_INIT[127:96]  + e, H_INIT[95:64]   + f,
                     H_INIT[63:32]   + g, H_INIT[31:0]    + h};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the SHA-256 block: known vectors, random messages,
// latency/throughput, mid-hash message changes and mid-hash reset.
module tb_top;

  logic         clk;
  logic         reset;
  logic         start;
  logic [119:0] message;
  logic [255:0] hashed;
  logic         start_abc;
  logic [23:0]  message_abc;
  logic [255:0] hashed_abc;

  int checks;
  int failures;

  top #(.MSG_SIZE(120)) dut (
    .clk(clk), .reset(reset), .start(start), .message(message), .hashed(hashed)
  );

  top #(.MSG_SIZE(24)) dut_abc (
    .clk(clk), .reset(reset), .start(start_abc), .message(message_abc), .hashed(hashed_abc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [31:0] MK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [119:0] B2B_MSG [4] = '{
    120'h4f6e6f6d6f6e6f7065612121212121, 120'h536173737953617371756174636821,
    120'h4c696c6f416e645374697463682121, 120'h4f535520526f636b73212121212121
  };
  localparam logic [31:0] B2B_HI [4] = '{32'ha9981acf, 32'h6c71746c, 32'h5ed99fcb, 32'hbad9a6c7};
  localparam logic [31:0] B2B_LO [4] = '{32'h8a4af676, 32'hee7a3b25, 32'h743f6262, 32'h77357828};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  // Bit-by-bit padding of a len-bit message held in the low bits of msg
  function automatic logic [511:0] pad(input logic [446:0] msg, input int len);
    logic [511:0] blk;
    blk = '0;
    for (int i = 0; i < len; i++) blk[511-i] = msg[len-1-i];
    blk[511-len] = 1'b1;
    blk[63:0] = 64'(len);
    return blk;
  endfunction

  // Straight FIPS 180-4 compression of one block with a full 64-word schedule
  function automatic logic [255:0] sha256_model(input logic [511:0] blk);
    logic [31:0] wm [64];
    logic [31:0] hv [8];
    logic [31:0] v [8];
    logic [31:0] s0, s1, tmp1, tmp2;
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int t = 0; t < 16; t++) wm[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(wm[t-15], 7) ^ ror(wm[t-15], 18) ^ (wm[t-15] >> 3);
      s1 = ror(wm[t-2], 17) ^ ror(wm[t-2], 19) ^ (wm[t-2] >> 10);
      wm[t] = s1 + wm[t-7] + s0 + wm[t-16];
    end
    v = hv;
    for (int t = 0; t < 64; t++) begin
      tmp1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + MK[t] + wm[t];
      tmp2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + tmp1;
      v[0] = tmp1 + tmp2;
    end
    return {hv[0] + v[0], hv[1] + v[1], hv[2] + v[2], hv[3] + v[3],
            hv[4] + v[4], hv[5] + v[5], hv[6] + v[6], hv[7] + v[7]};
  endfunction

  function automatic logic [255:0] model120(input logic [119:0] m);
    return sha256_model(pad({327'd0, m}, 120));
  endfunction

  function automatic logic [119:0] rand_msg();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Counts edges until the selected digest changes; n stays -1 on timeout
  task automatic measure(input bit sel, input int max_edges, input int change_at,
                         input logic [119:0] change_msg, output int n, output logic [255:0] val);
    logic [255:0] prev;
    logic [255:0] cur;
    prev = sel ? hashed_abc : hashed;
    n = -1;
    for (int k = 1; k <= max_edges; k++) begin
      @(posedge clk);
      #1;
      if (k == change_at) message = change_msg;
      cur = sel ? hashed_abc : hashed;
      if (cur !== prev) begin
        n = k;
        break;
      end
    end
    val = sel ? hashed_abc : hashed;
  endtask

  task automatic wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start_abc = 1'b0;
    message = '0;
    message_abc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (hashed !== 256'h0) begin
      failures++;
      $display("[TB] FAIL reset_hashed: got %h expected 0", hashed);
    end
    checks++;
    if (hashed_abc !== 256'h0) begin
      failures++;
      $display("[TB] FAIL reset_hashed_abc: got %h expected 0", hashed_abc);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (hashed !== 256'h0) begin
      failures++;
      $display("[TB] FAIL idle_hold: got %h expected 0", hashed);
    end
  endtask

  task automatic test_abc();
    int n;
    logic [255:0] val;
    logic [23:0] m;
    @(negedge clk);
    message_abc = 24'h616263;
    start_abc = 1'b1;
    @(posedge clk);
    #1;
    start_abc = 1'b0;
    measure(1'b1, 200, -1, '0, n, val);
    checks++;
    if (n !== 65) begin
      failures++;
      $display("[TB] FAIL abc_latency: got %0d edges expected 65", n);
    end
    checks++;
    if (val !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      failures++;
      $display("[TB] FAIL abc_digest: got %h", val);
    end
    wait_idle();
    m = 24'($urandom);
    message_abc = m;
    start_abc = 1'b1;
    @(posedge clk);
    #1;
    start_abc = 1'b0;
    measure(1'b1, 200, -1, '0, n, val);
    checks++;
    if (val !== sha256_model(pad({423'd0, m}, 24))) begin
      failures++;
      $display("[TB] FAIL abc_random: got %h expected %h", val, sha256_model(pad({423'd0, m}, 24)));
    end
  endtask

  task automatic test_known_vector();
    int n;
    logic [255:0] val;
    wait_idle();
    message = 120'h48656c6c6f2c205348412d32353621;
    start = 1'b1;
    @(posedge clk);
    #1;
    measure(1'b0, 200, -1, '0, n, val);
    checks++;
    if (n !== 65) begin
      failures++;
      $display("[TB] FAIL known_latency: got %0d edges expected 65", n);
    end
    checks++;
    if (val !== 256'hd0e8b8f11c98f369016eb2ed3c541e1f01382f9d5b3104c9ffd06b6175a46271) begin
      failures++;
      $display("[TB] FAIL known_digest: got %h", val);
    end
    checks++;
    if (val !== model120(message)) begin
      failures++;
      $display("[TB] FAIL known_model: got %h expected %h", val, model120(message));
    end
  endtask

  // start stays high; each new message is presented right after the previous update
  task automatic test_back_to_back();
    int n;
    logic [255:0] val;
    logic [119:0] m;
    for (int i = 0; i < 7; i++) begin
      m = (i < 4) ? B2B_MSG[i] : rand_msg();
      message = m;
      measure(1'b0, 200, -1, '0, n, val);
      checks++;
      if (n !== 67) begin
        failures++;
        $display("[TB] FAIL b2b_period[%0d]: got %0d edges expected 67", i, n);
      end
      checks++;
      if (val !== model120(m)) begin
        failures++;
        $display("[TB] FAIL b2b_digest[%0d]: got %h expected %h", i, val, model120(m));
      end
      if (i < 4) begin
        checks++;
        if (val[255:224] !== B2B_HI[i] || val[31:0] !== B2B_LO[i]) begin
          failures++;
          $display("[TB] FAIL b2b_vector[%0d]: got %h..%h expected %h..%h",
                   i, val[255:224], val[31:0], B2B_HI[i], B2B_LO[i]);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    int n;
    logic [255:0] val;
    logic [255:0] held;
    logic [119:0] m;
    start = 1'b0;
    held = hashed;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (hashed !== held) begin
      failures++;
      $display("[TB] FAIL hold_after_done: got %h expected %h", hashed, held);
    end
    @(negedge clk);
    m = rand_msg();
    message = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    measure(1'b0, 200, 10, rand_msg(), n, val);
    checks++;
    if (n !== 65) begin
      failures++;
      $display("[TB] FAIL midchange_latency: got %0d edges expected 65", n);
    end
    checks++;
    if (val !== model120(m)) begin
      failures++;
      $display("[TB] FAIL midchange_digest: got %h expected %h", val, model120(m));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [255:0] val;
    logic [119:0] m;
    bit changed;
    wait_idle();
    message = rand_msg();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (hashed !== 256'h0) begin
      failures++;
      $display("[TB] FAIL midreset_clear: got %h expected 0", hashed);
    end
    @(negedge clk);
    reset = 1'b0;
    changed = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (hashed !== 256'h0) changed = 1'b1;
    end
    checks++;
    if (changed) begin
      failures++;
      $display("[TB] FAIL midreset_no_update: got hashed=%h expected 0 throughout", hashed);
    end
    @(negedge clk);
    m = rand_msg();
    message = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    measure(1'b0, 200, -1, '0, n, val);
    checks++;
    if (n !== 65) begin
      failures++;
      $display("[TB] FAIL afterreset_latency: got %0d edges expected 65", n);
    end
    checks++;
    if (val !== model120(m)) begin
      failures++;
      $display("[TB] FAIL afterreset_digest: got %h expected %h", val, model120(m));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_abc();
    test_known_vector();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter MSG_SIZE, default 120, message length in bits; legal range 1..447, so the padded message is exactly one 512-bit block.
REQ-002 Parameter PADDED_SIZE, default 512, padded block width in bits; fixed at 512.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to hash; level-sensitive and may be held high indefinitely.
REQ-006 message  input  MSG_SIZE  message bits; bit MSG_SIZE-1 is the first message bit (first byte in the MSBs).
REQ-007 hashed  output  256  SHA-256 digest, H0 in bits 255:224 through H7 in bits 31:0; registered.

Function
REQ-008 The block SHALL compute the FIPS 180-4 SHA-256 digest of the MSG_SIZE-bit message.
REQ-009 Padded block = message, then a single 1 bit, then zeros, then a 64-bit big-endian MSG_SIZE in bits 63:0 of the block.
REQ-010 FSM states: IDLE, COMPUTE, FINAL, DONE.
REQ-011 IDLE with start=1 at edge E0: latch the padded block into a 16-word schedule window, load a..h with the standard initial H constants, clear the round counter to 0, and enter COMPUTE.
REQ-012 IDLE with start=0: remain in IDLE; hashed holds its value.
REQ-013 COMPUTE: one round per edge (E1..E64), round t uses K[t] and W[t]; rounds 0..15 use the latched words, and rounds 16..63 use W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16] computed in a sliding 16-word window.
REQ-014 All additions are modulo 2^32; the K table holds the 64 FIPS constants as combinational ROM.
REQ-015 After round 63, enter FINAL; at E65, hashed <= {H0+a, ..., H7+h} and the FSM enters DONE.
REQ-016 DONE at E66: return to IDLE unconditionally; if start is still high, a new hash begins at E67 using the message value present then.
REQ-017 Latency: hashed updates exactly 65 rising edges after the capturing edge E0; back-to-back throughput is one hash per 67 cycles.
REQ-018 message and start changes during COMPUTE/FINAL/DONE SHALL NOT affect the hash in progress; only the latched block is used.
REQ-019 hashed changes only at the FINAL edge or on reset and stays stable otherwise, including while a subsequent hash computes.

Reset
REQ-020 reset=1 at a rising edge: state <= IDLE, hashed <= 256'h0, round counter, a..h and the schedule window cleared.
REQ-021 reset has priority over all other activity; a reset mid-operation aborts the hash with no hashed update, and the next start begins afresh.
REQ-022 After reset deasserts, the first capture occurs at the first edge with start=1.

Verification
REQ-023 MSG_SIZE=120, message=0x48656c6c6f2c205348412d32353621, start held high -> hashed=0xd0e8b8f11c98f369016eb2ed3c541e1f01382f9d5b3104c9ffd06b6175a46271 exactly 65 edges after capture.
REQ-024 start kept high while message steps through 0x4f6e6f6d6f6e6f7065612121212121, 0x536173737953617371756174636821, 0x4c696c6f416e645374697463682121 and 0x4f535520526f636b73212121212121 -> hashed reaches, in order, a9981acf...8a4af676, 6c71746c...ee7a3b25, 5ed99fcb...743f6262 and bad9a6c7...77357828, with zero mismatches.
REQ-025 MSG_SIZE=24, message=0x616263 ("abc") -> hashed=0xba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-026 Assert reset at round 30 of a hash -> hashed=0 on the next edge with no later update; after reset drops and start rises, the correct digest follows 65 edges after capture.
REQ-027 Change message at E10 of a hash -> the digest still matches the message captured at E0, and hashed stays constant outside FINAL edges.
